// File: rtl/trng_byte_collector.sv
// TRNG receive side: packs debiased bits MSB-first into bytes, buffers them in a
// small FIFO for a valid/ready consumer, and stops collection on a repetition-count fault.
module trng_byte_collector #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_clear,
  input  logic                       i_random,
  input  logic                       i_valid,
  output logic [7:0]                 o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow,
  output logic                       o_health_fail
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FAIL    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      rep_q, rep_d;
  logic            last_q, last_d;

  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            ovf_q, ovf_d;
  logic            hf_q, hf_d;

  logic            collect_c;
  logic            sample_c;
  logic            trip_c;
  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            wr_en_c;
  logic [7:0]      byte_c;
  logic [7:0]      rep_next_c;
  logic [PW-1:0]   rd_next_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (i_en) state_d = ST_COLLECT;
        ST_COLLECT: begin
          if (!i_en)       state_d = ST_IDLE;
          else if (trip_c) state_d = ST_FAIL;
        end
        ST_FAIL:    state_d = ST_FAIL;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Bits are only accepted while actively collecting and not being cleared or disabled
  always_comb begin
    collect_c = 1'b0;
    if (state_q == ST_COLLECT) collect_c = i_en & ~i_clear;
    sample_c = collect_c & i_valid;
  end

  // Shift register, bit counter and repetition counter; rep_q == 0 marks "no bit seen yet"
  always_comb begin
    rep_next_c = (rep_q != 8'd0 && i_random == last_q) ? rep_q + 8'd1 : 8'd1;
    trip_c     = sample_c && (rep_next_c == 8'(REP_LIMIT));
    byte_c     = {shift_q, i_random};
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    rep_d      = rep_q;
    last_d     = last_q;
    push_c     = 1'b0;
    if (!collect_c) begin
      bitcnt_d = 3'd0;
      rep_d    = 8'd0;
    end else if (i_valid) begin
      shift_d = byte_c[6:0];
      last_d  = i_random;
      if (trip_c) begin
        bitcnt_d = 3'd0;
        rep_d    = 8'd0;
      end else begin
        rep_d = rep_next_c;
        if (bitcnt_q == 3'd7) begin
          push_c   = 1'b1;
          bitcnt_d = 3'd0;
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
    end
  end

  // FIFO control; the head byte is registered so o_data is a flop output
  always_comb begin
    pop_c     = dv_q & i_data_ready & ~i_clear;
    full_c    = (count_q == LW'(DEPTH));
    wr_en_c   = push_c & (~full_c | pop_c);
    rd_next_c = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d  = wr_en_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_next_c;
    count_d   = count_q + LW'(wr_en_c) - LW'(pop_c);
    ovf_d     = ovf_q | (push_c & full_c & ~pop_c);
    hf_d      = hf_q | trip_c;
    dv_d      = (count_d != '0);
    data_d    = data_q;
    if (count_d != '0) begin
      data_d = (wr_en_c && (wr_ptr_q == rd_next_c)) ? byte_c : mem_q[rd_next_c];
    end
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      hf_d     = 1'b0;
      dv_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      rep_q    <= '0;
      last_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      hf_q     <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      hf_q     <= hf_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= byte_c;
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = dv_q;
  assign o_level       = count_q;
  assign o_overflow    = ovf_q;
  assign o_health_fail = hf_q;

endmodule
